// File: rtl/relu_act_buffer_if.sv
// Write-stream and drain-stream bundle for relu_act_buffer.
// The master side drives writes and drain ready. The slave side is the buffer.
interface relu_act_buffer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              in_valid;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_data;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;

    modport master (
        output in_valid, in_addr, in_data, out_ready,
        input  out_valid, out_data, out_addr, out_last
    );

    modport slave (
        input  in_valid, in_addr, in_data, out_ready,
        output out_valid, out_data, out_addr, out_last
    );
endinterface

// File: rtl/relu_act_buffer.sv
// Collects one frame of ReLU activations and then drains it in address order.
// Optional ACT_BUF_ZERO_CNT_EN adds a saturating count of zero-valued writes on zero_cnt_o.
module relu_act_buffer #(
    parameter int DEPTH  = 32,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [5:0]         frame_len_i,
    relu_act_buffer_if.slave   bus,
    output logic               busy_o,
    output logic               frame_done_o,
    output logic               err_dup_o,
    output logic               err_drop_o,
    output logic [5:0]         zero_cnt_o
);
    // Shared width for comparing addresses against the 6-bit frame length.
    localparam int CW = (ADDR_W > 6) ? ADDR_W : 6;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  fill_q, fill_d;
    logic [DEPTH-1:0]  hit_vec;
    logic [5:0]        len_q, len_d;
    logic [5:0]        count_q, count_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic              err_dup_q, err_dup_d;
    logic              err_drop_q, err_drop_d;
    logic              frame_done_q, frame_done_d;

    logic len_ok, start_acc, in_range, wr_acc, hit, wr_new, drop;
    logic xfer, is_last, collect_done;

    assign len_ok       = (frame_len_i != 6'd0) && (frame_len_i <= 6'(DEPTH));
    assign start_acc    = (state_q == S_IDLE) && start_i && len_ok;
    assign in_range     = CW'(bus.in_addr) < CW'(len_q);
    assign wr_acc       = (state_q == S_COLLECT) && bus.in_valid && in_range;
    assign hit          = |hit_vec;
    assign wr_new       = wr_acc && !hit;
    assign drop         = bus.in_valid && (((state_q == S_IDLE) && !start_acc) ||
                                           ((state_q == S_COLLECT) && !in_range) ||
                                           (state_q == S_DRAIN));
    assign xfer         = (state_q == S_DRAIN) && bus.out_ready;
    assign is_last      = CW'(rd_ptr_q) == (CW'(len_q) - CW'(1));
    assign collect_done = (state_q == S_COLLECT) && wr_new && ((count_q + 6'd1) == len_q);

    // Per-entry fill tracking: a hit means this address already arrived in the frame.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_fill
            assign hit_vec[gi] = fill_q[gi] && (CW'(bus.in_addr) == CW'(gi));
            assign fill_d[gi]  = start_acc ? 1'b0 :
                                 (fill_q[gi] || (wr_acc && (CW'(bus.in_addr) == CW'(gi))));
        end
    endgenerate

    always_comb begin
        len_d        = start_acc ? frame_len_i : len_q;
        count_d      = start_acc ? 6'd0 : (wr_new ? count_q + 6'd1 : count_q);
        err_dup_d    = start_acc ? 1'b0 : (err_dup_q || (wr_acc && hit));
        err_drop_d   = start_acc ? 1'b0 : (err_drop_q || drop);
        frame_done_d = collect_done;
        rd_ptr_d     = rd_ptr_q;
        if (collect_done) begin
            rd_ptr_d = '0;
        end else if (xfer) begin
            rd_ptr_d = is_last ? '0 : rd_ptr_q + ADDR_W'(1);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            fill_q       <= '0;
            len_q        <= '0;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            err_dup_q    <= 1'b0;
            err_drop_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_q       <= fill_d;
            len_q        <= len_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            err_dup_q    <= err_dup_d;
            err_drop_q   <= err_drop_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Storage is deliberately left unreset; only entries written this frame are drained.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[bus.in_addr] <= bus.in_data;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start_acc) state_d = S_COLLECT;
            S_COLLECT: if (collect_done) state_d = S_DRAIN;
            S_DRAIN:   if (xfer && is_last) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy_o        = (state_q != S_IDLE);
        bus.out_valid = (state_q == S_DRAIN);
        bus.out_addr  = '0;
        bus.out_data  = '0;
        bus.out_last  = 1'b0;
        if (state_q == S_DRAIN) begin
            bus.out_addr = rd_ptr_q;
            bus.out_data = mem[rd_ptr_q];
            bus.out_last = is_last;
        end
        frame_done_o = frame_done_q;
        err_dup_o    = err_dup_q;
        err_drop_o   = err_drop_q;
    end

`ifdef ACT_BUF_ZERO_CNT_EN
    logic [5:0] zero_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_cnt_q <= '0;
        end else if (start_acc) begin
            zero_cnt_q <= '0;
        end else if (wr_acc && (bus.in_data == '0) && (zero_cnt_q != 6'd63)) begin
            zero_cnt_q <= zero_cnt_q + 6'd1;
        end
    end

    assign zero_cnt_o = zero_cnt_q;
`else
    assign zero_cnt_o = '0;
`endif

endmodule

// File: tb/tb_relu_act_buffer.sv
// Directed bench for relu_act_buffer: frame collection, drain handshake, error flags, reset abort.
// Expected drain words come from hand-filled tables in each scenario.
module tb_relu_act_buffer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [5:0] frame_len;
    logic       busy, frame_done, err_dup, err_drop;
    logic [5:0] zero_cnt;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_mem [32];

    relu_act_buffer_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    relu_act_buffer #(.DEPTH(32), .DATA_W(32), .ADDR_W(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start),
        .frame_len_i  (frame_len),
        .bus          (bus.slave),
        .busy_o       (busy),
        .frame_done_o (frame_done),
        .err_dup_o    (err_dup),
        .err_drop_o   (err_drop),
        .zero_cnt_o   (zero_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [5:0] len);
        start     = 1'b1;
        frame_len = len;
        tick();
        start     = 1'b0;
    endtask

    task automatic write(input logic [4:0] addr, input logic [31:0] data);
        bus.in_valid = 1'b1;
        bus.in_addr  = addr;
        bus.in_data  = data;
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Full-rate drain of n words from exp_mem; frame_done must be high on word 0 only.
    task automatic drain_check(input string tag, input int n);
        logic [39:0] got, want;
        logic [4:0]  a;
        bus.out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            a    = 5'(i);
            got  = {frame_done, bus.out_valid, bus.out_last, bus.out_addr, bus.out_data};
            want = {(i == 0), 1'b1, (i == n - 1), a, exp_mem[i]};
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL %s_word%0d: got {fd,v,last,addr,data}=%h required %h", tag, i, got, want);
            end
            tick();
        end
        bus.out_ready = 1'b0;
        checks++;
        if ({busy, bus.out_valid, frame_done} !== 3'b000) begin
            failures++;
            $display("FAIL %s_idle: got {busy,valid,fd}=%b required 000", tag, {busy, bus.out_valid, frame_done});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({busy, frame_done, err_dup, err_drop, zero_cnt, bus.out_valid, bus.out_last,
             bus.out_addr, bus.out_data} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b fd=%b dup=%b drop=%b zc=%0d v=%b addr=%0d data=%h required all 0",
                     busy, frame_done, err_dup, err_drop, zero_cnt, bus.out_valid, bus.out_addr, bus.out_data);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({busy, bus.out_valid, err_drop} !== 3'b000) begin
            failures++;
            $display("FAIL reset_release: got {busy,valid,drop}=%b required 000", {busy, bus.out_valid, err_drop});
        end
    endtask

    task automatic load_t1_frame();
        do_start(6'd4);
        write(5'd3, 32'h0100_0000);
        write(5'd1, 32'h0200_0000);
        write(5'd0, 32'h0000_0000);
        write(5'd2, 32'h0080_0000);
        exp_mem[0] = 32'h0000_0000;
        exp_mem[1] = 32'h0200_0000;
        exp_mem[2] = 32'h0080_0000;
        exp_mem[3] = 32'h0100_0000;
    endtask

    task automatic test_basic_frame();
        logic [5:0] zc_exp;
        load_t1_frame();
        drain_check("basic", 4);
`ifdef ACT_BUF_ZERO_CNT_EN
        zc_exp = 6'd1;
`else
        zc_exp = 6'd0;
`endif
        checks++;
        if (zero_cnt !== zc_exp) begin
            failures++;
            $display("FAIL basic_zero_cnt: got %0d required %0d", zero_cnt, zc_exp);
        end
    endtask

    task automatic test_backpressure();
        logic [39:0] got, want;
        logic [4:0]  a;
        load_t1_frame();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            got  = {frame_done, bus.out_valid, bus.out_last, bus.out_addr, bus.out_data};
            want = {1'b0, 1'b1, 1'b0, 5'd1, 32'h0200_0000};
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL stall_hold%0d: got {fd,v,last,addr,data}=%h required %h", c, got, want);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            a    = 5'(i);
            got  = {bus.out_valid, bus.out_last, bus.out_addr, bus.out_data};
            want = {1'b1, (i == 3), a, exp_mem[i]};
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL stall_resume%0d: got {v,last,addr,data}=%h required %h", i, got, want);
            end
            tick();
        end
        bus.out_ready = 1'b0;
        checks++;
        if ({busy, bus.out_valid} !== 2'b00) begin
            failures++;
            $display("FAIL stall_idle: got {busy,valid}=%b required 00", {busy, bus.out_valid});
        end
    endtask

    task automatic test_duplicate();
        do_start(6'd2);
        write(5'd1, 32'd5);
        write(5'd1, 32'd7);
        checks++;
        if ({err_dup, busy, bus.out_valid, frame_done} !== 4'b1100) begin
            failures++;
            $display("FAIL dup_flag: got {dup,busy,valid,fd}=%b required 1100",
                     {err_dup, busy, bus.out_valid, frame_done});
        end
        write(5'd0, 32'd9);
        exp_mem[0] = 32'd9;
        exp_mem[1] = 32'd7;
        drain_check("dup", 2);
        checks++;
        if (err_dup !== 1'b1) begin
            failures++;
            $display("FAIL dup_sticky: got %b required 1", err_dup);
        end
    endtask

    task automatic test_drop();
        bus.in_valid = 1'b1;
        bus.in_addr  = 5'd0;
        bus.in_data  = 32'h1234_5678;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if ({err_drop, busy} !== 2'b10) begin
            failures++;
            $display("FAIL drop_idle: got {drop,busy}=%b required 10", {err_drop, busy});
        end
        // Start and write in the same cycle: the clear wins and no flag is raised.
        bus.in_valid = 1'b1;
        bus.in_addr  = 5'd0;
        bus.in_data  = 32'h0000_00AA;
        do_start(6'd4);
        bus.in_valid = 1'b0;
        checks++;
        if ({err_drop, err_dup, busy} !== 3'b001) begin
            failures++;
            $display("FAIL drop_start_clear: got {drop,dup,busy}=%b required 001", {err_drop, err_dup, busy});
        end
        write(5'd5, 32'hDEAD_BEEF);
        checks++;
        if (err_drop !== 1'b1) begin
            failures++;
            $display("FAIL drop_range: got %b required 1", err_drop);
        end
        write(5'd0, 32'h11);
        write(5'd1, 32'h22);
        write(5'd2, 32'h33);
        checks++;
        if ({bus.out_valid, busy} !== 2'b01) begin
            failures++;
            $display("FAIL drop_count: got {valid,busy}=%b required 01", {bus.out_valid, busy});
        end
        write(5'd3, 32'h44);
        exp_mem[0] = 32'h11;
        exp_mem[1] = 32'h22;
        exp_mem[2] = 32'h33;
        exp_mem[3] = 32'h44;
        drain_check("drop", 4);
    endtask

    task automatic test_len_bounds();
        logic [4:0] a;
        do_start(6'd0);
        checks++;
        if ({busy, err_drop} !== 2'b01) begin
            failures++;
            $display("FAIL len0_ignored: got {busy,drop}=%b required 01", {busy, err_drop});
        end
        do_start(6'd33);
        checks++;
        if ({busy, err_drop} !== 2'b01) begin
            failures++;
            $display("FAIL len33_ignored: got {busy,drop}=%b required 01", {busy, err_drop});
        end
        do_start(6'd32);
        for (int i = 0; i < 32; i++) begin
            a = 5'(31 - i);
            exp_mem[a] = 32'hA500_0000 | 32'(a);
            write(a, exp_mem[a]);
            if (i == 30) begin
                checks++;
                if (bus.out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL len32_early: got valid=%b required 0 after 31 writes", bus.out_valid);
                end
            end
        end
        drain_check("len32", 32);
    endtask

    task automatic test_reset_mid();
        do_start(6'd4);
        write(5'd0, 32'h0);
        write(5'd1, 32'h0300_0000);
        write(5'd7, 32'h5);
        rst_n = 1'b0;
        #2;
        checks++;
        if ({busy, frame_done, err_dup, err_drop, zero_cnt, bus.out_valid, bus.out_last,
             bus.out_addr, bus.out_data} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs: got busy=%b fd=%b dup=%b drop=%b zc=%0d v=%b required all 0",
                     busy, frame_done, err_dup, err_drop, zero_cnt, bus.out_valid);
        end
        tick();
        rst_n = 1'b1;
        tick();
        do_start(6'd3);
        write(5'd2, 32'hC);
        write(5'd0, 32'hA);
        write(5'd1, 32'hB);
        exp_mem[0] = 32'hA;
        exp_mem[1] = 32'hB;
        exp_mem[2] = 32'hC;
        drain_check("postreset", 3);
    endtask

    initial begin
        rst_n         = 1'b0;
        start         = 1'b0;
        frame_len     = 6'd0;
        bus.in_valid  = 1'b0;
        bus.in_addr   = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_duplicate();
        test_drop();
        test_len_bounds();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
